rom_bus_arbiter: RTL and testbench

// Shares the 16 KB boot/program ROM between two requesters: the Beaker8 CPU

---
 rtl/beaker8_bus_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/rom_bus_arbiter.sv | 118 +++++++++++
 tb/tb_rom_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beaker8_bus_pkg.sv
// Shared types and constants for the Beaker8 system bus blocks.
//   rom_arb_state_t : ROM arbiter FSM states
//   REQ_CPU/REQ_DMA : requester ids used for grant and last_grant
//   ROM_ADDR_W/DATA_W : default ROM geometry (16 KB x 8)
package beaker8_bus_pkg;
  localparam int ROM_ADDR_W = 14;
  localparam int DATA_W     = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } rom_arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter (combinational).
//   req_cpu, req_dma : pending requests
//   last_grant       : id of the requester granted most recently
//   gnt_valid        : at least one request is pending
//   gnt_id           : winning requester id (REQ_CPU / REQ_DMA)
module rr_arbiter2
  import beaker8_bus_pkg::REQ_CPU;
  import beaker8_bus_pkg::REQ_DMA;
(
  input  logic req_cpu,
  input  logic req_dma,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  always_comb begin
    gnt_valid = req_cpu | req_dma;
    gnt_id    = REQ_CPU;
    if (req_cpu && req_dma)
      // On a tie the requester that did not win last time goes first.
      gnt_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
    else if (req_dma)
      gnt_id = REQ_DMA;
  end
endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares the boot/program ROM between the CPU port and the DMA/video port.
// A request is registered in IDLE, the ROM is selected for WAIT_STATES+1
// cycles (ACCESS), the byte is latched on the last ACCESS edge and the
// granted requester gets a one-cycle ack (DONE).
//   clk, reset              : clock, async active-high reset
//   cpu_req/addr, cpu_ack/data : CPU read port
//   dma_req/addr, dma_ack/data : DMA read port
//   rom_cs, rom_addr, rom_data : ROM interface (rom_addr registered)
//   busy                    : FSM not in IDLE
module rom_bus_arbiter #(
  parameter int ADDR_W      = beaker8_bus_pkg::ROM_ADDR_W,
  parameter int DATA_W      = beaker8_bus_pkg::DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_data,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  import beaker8_bus_pkg::rom_arb_state_t;
  import beaker8_bus_pkg::IDLE;
  import beaker8_bus_pkg::ACCESS;
  import beaker8_bus_pkg::DONE;
  import beaker8_bus_pkg::REQ_CPU;
  import beaker8_bus_pkg::REQ_DMA;

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  rom_arb_state_t    state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0] dma_data_q, dma_data_d;
  logic              arb_valid, arb_id;

  rr_arbiter2 u_arb (
    .req_cpu    (cpu_req),
    .req_dma    (dma_req),
    .last_grant (last_grant_q),
    .gnt_valid  (arb_valid),
    .gnt_id     (arb_id)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rom_addr_d   = rom_addr_q;
    cpu_data_d   = cpu_data_q;
    dma_data_d   = dma_data_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_id;
          last_grant_d = arb_id;
          rom_addr_d   = (arb_id == REQ_DMA) ? dma_addr : cpu_addr;
          cnt_d        = CNT_LOAD;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Last select cycle: ROM output is settled, capture it.
          if (grant_q == REQ_DMA) dma_data_d = rom_data;
          else                    cpu_data_d = rom_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_DMA;  // makes the first tie go to the CPU
      cnt_q        <= '0;
      rom_addr_q   <= '0;
      cpu_data_q   <= '0;
      dma_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rom_addr_q   <= rom_addr_d;
      cpu_data_q   <= cpu_data_d;
      dma_data_q   <= dma_data_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign rom_cs   = (state_q == ACCESS);
  assign busy     = (state_q != IDLE);
  assign cpu_ack  = (state_q == DONE) && (grant_q == REQ_CPU);
  assign dma_ack  = (state_q == DONE) && (grant_q == REQ_DMA);
  assign rom_addr = rom_addr_q;
  assign cpu_data = cpu_data_q;
  assign dma_data = dma_data_q;
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Bench for rom_bus_arbiter: instance 0 has WAIT_STATES=0, instance 1 has
// WAIT_STATES=1. A timeline model (access start cycle, grant order) checks
// every output of both instances every cycle; scenario tasks add fixed-value
// checks from the documented timing.
module tb_rom_bus_arbiter;
  logic        clk, rst;
  logic        cpu_req [2], dma_req [2], cpu_ack [2], dma_ack [2], rom_cs [2], busy [2];
  logic [13:0] cpu_addr [2], dma_addr [2], rom_addr [2];
  logic [7:0]  cpu_data [2], dma_data [2], rom_data [2];
  logic [7:0]  rom [16384];

  int checks = 0, errors = 0, cyc = 0;
  // model state
  int          m_start [2];
  int          m_who [2];
  logic [13:0] m_addr [2];
  int          m_last [2];
  logic [7:0]  m_cd [2], m_dd [2];
  int          glog [$];

  assign rom_data[0] = rom_cs[0] ? rom[rom_addr[0]] : 8'h00;
  assign rom_data[1] = rom_cs[1] ? rom[rom_addr[1]] : 8'h00;

  rom_bus_arbiter #(.ADDR_W(14), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req[0]), .cpu_addr(cpu_addr[0]), .cpu_ack(cpu_ack[0]), .cpu_data(cpu_data[0]),
    .dma_req(dma_req[0]), .dma_addr(dma_addr[0]), .dma_ack(dma_ack[0]), .dma_data(dma_data[0]),
    .rom_cs(rom_cs[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .busy(busy[0]));

  rom_bus_arbiter #(.ADDR_W(14), .DATA_W(8), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req[1]), .cpu_addr(cpu_addr[1]), .cpu_ack(cpu_ack[1]), .cpu_data(cpu_data[1]),
    .dma_req(dma_req[1]), .dma_addr(dma_addr[1]), .dma_ack(dma_ack[1]), .dma_data(dma_data[1]),
    .rom_cs(rom_cs[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(int i);
    return (i == 0) ? 0 : 1;
  endfunction

  // Check the current cycle of both instances against the model, let the
  // model arbitrate on the current inputs, then advance one clock.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      bit acc, done;
      acc  = (m_start[i] >= 0) && (cyc >= m_start[i]) && (cyc <= m_start[i] + ws(i));
      done = (m_start[i] >= 0) && (cyc == m_start[i] + ws(i) + 1);
      if (done) begin
        if (m_who[i] == 0) m_cd[i] = rom[m_addr[i]];
        else               m_dd[i] = rom[m_addr[i]];
      end
      checks++; if (rom_cs[i] !== acc) begin errors++;
        $display("FAIL rom_cs inst%0d cyc%0d: got %b want %b", i, cyc, rom_cs[i], acc); end
      checks++; if (busy[i] !== (acc | done)) begin errors++;
        $display("FAIL busy inst%0d cyc%0d: got %b want %b", i, cyc, busy[i], acc | done); end
      checks++; if (cpu_ack[i] !== (done && m_who[i] == 0)) begin errors++;
        $display("FAIL cpu_ack inst%0d cyc%0d: got %b want %b", i, cyc, cpu_ack[i], done && m_who[i] == 0); end
      checks++; if (dma_ack[i] !== (done && m_who[i] == 1)) begin errors++;
        $display("FAIL dma_ack inst%0d cyc%0d: got %b want %b", i, cyc, dma_ack[i], done && m_who[i] == 1); end
      if (acc) begin
        checks++; if (rom_addr[i] !== m_addr[i]) begin errors++;
          $display("FAIL rom_addr inst%0d cyc%0d: got %h want %h", i, cyc, rom_addr[i], m_addr[i]); end
      end
      checks++; if (cpu_data[i] !== m_cd[i]) begin errors++;
        $display("FAIL cpu_data inst%0d cyc%0d: got %h want %h", i, cyc, cpu_data[i], m_cd[i]); end
      checks++; if (dma_data[i] !== m_dd[i]) begin errors++;
        $display("FAIL dma_data inst%0d cyc%0d: got %h want %h", i, cyc, dma_data[i], m_dd[i]); end
      // requester drops its request once acked
      if (done) begin
        if (m_who[i] == 0) cpu_req[i] = 1'b0; else dma_req[i] = 1'b0;
      end
      if (!acc && !done) begin
        m_start[i] = -1;
        if (cpu_req[i] || dma_req[i]) begin
          if (cpu_req[i] && dma_req[i]) m_who[i] = 1 - m_last[i];
          else                          m_who[i] = dma_req[i] ? 1 : 0;
          m_last[i]  = m_who[i];
          m_addr[i]  = (m_who[i] == 1) ? dma_addr[i] : cpu_addr[i];
          m_start[i] = cyc + 1;
          if (i == 1) glog.push_back(m_who[i]);
        end
      end
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1'b0; dma_req[i] = 1'b0; cpu_addr[i] = '0; dma_addr[i] = '0;
      m_start[i] = -1; m_last[i] = 1; m_cd[i] = 8'h00; m_dd[i] = 8'h00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({rom_cs[i], busy[i], cpu_ack[i], dma_ack[i]} !== 4'b0) begin errors++;
        $display("FAIL reset_ctl inst%0d: got %b want 0000", i, {rom_cs[i], busy[i], cpu_ack[i], dma_ack[i]}); end
      checks++; if (rom_addr[i] !== 14'h0) begin errors++;
        $display("FAIL reset_addr inst%0d: got %h want 0", i, rom_addr[i]); end
      checks++; if ({cpu_data[i], dma_data[i]} !== 16'h0) begin errors++;
        $display("FAIL reset_data inst%0d: got %h want 0", i, {cpu_data[i], dma_data[i]}); end
    end
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_cpu_only();
    cpu_req[1] = 1'b1; cpu_addr[1] = 14'h0000;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rom_cs[1] !== (k == 1 || k == 2)) begin errors++;
        $display("FAIL cpu_only_cs k%0d: got %b want %b", k, rom_cs[1], k == 1 || k == 2); end
      checks++; if (cpu_ack[1] !== (k == 3)) begin errors++;
        $display("FAIL cpu_only_ack k%0d: got %b want %b", k, cpu_ack[1], k == 3); end
      checks++; if (dma_ack[1] !== 1'b0) begin errors++;
        $display("FAIL cpu_only_dma_ack k%0d: got %b want 0", k, dma_ack[1]); end
      tick();
    end
    checks++; if (cpu_data[1] !== 8'hF3) begin errors++;
      $display("FAIL cpu_only_data: got %h want f3", cpu_data[1]); end
  endtask

  task automatic test_reset_mid_access();
    cpu_req[1] = 1'b1; cpu_addr[1] = 14'h0002;
    tick(); tick();          // now in cycle 2, second ACCESS cycle
    rst = 1'b1;
    #1;
    checks++; if ({rom_cs[1], busy[1], cpu_ack[1]} !== 3'b000) begin errors++;
      $display("FAIL mid_reset_ctl: got %b want 000", {rom_cs[1], busy[1], cpu_ack[1]}); end
    checks++; if (cpu_data[1] !== 8'h00) begin errors++;
      $display("FAIL mid_reset_data: got %h want 00", cpu_data[1]); end
    model_reset();
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    repeat (4) tick();       // no ack may appear
  endtask

  task automatic test_both_same_edge();
    int c0, ca, da;
    c0 = cyc; ca = -1; da = -1;
    cpu_req[1] = 1'b1; cpu_addr[1] = 14'h0010;
    dma_req[1] = 1'b1; dma_addr[1] = 14'h3FFF;
    for (int k = 0; k < 12; k++) begin
      if (cpu_ack[1] === 1'b1 && ca < 0) ca = cyc - c0;
      if (dma_ack[1] === 1'b1 && da < 0) da = cyc - c0;
      tick();
    end
    checks++; if (ca !== 3) begin errors++; $display("FAIL both_cpu_ack_cycle: got %0d want 3", ca); end
    checks++; if (da !== 7) begin errors++; $display("FAIL both_dma_ack_cycle: got %0d want 7", da); end
    checks++; if (dma_data[1] !== rom[16383]) begin errors++;
      $display("FAIL both_dma_data: got %h want %h", dma_data[1], rom[16383]); end
    checks++; if (cpu_data[1] !== rom[16]) begin errors++;
      $display("FAIL both_cpu_data: got %h want %h", cpu_data[1], rom[16]); end
    // second tie: last grant was DMA, so the CPU wins again
    c0 = cyc; ca = -1; da = -1;
    cpu_req[1] = 1'b1; dma_req[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cpu_ack[1] === 1'b1 && ca < 0) ca = cyc - c0;
      if (dma_ack[1] === 1'b1 && da < 0) da = cyc - c0;
      tick();
    end
    checks++; if (ca !== 3 || da !== 7) begin errors++;
      $display("FAIL both_again_order: got cpu@%0d dma@%0d want cpu@3 dma@7", ca, da); end
  endtask

  task automatic test_alternate();
    int n;
    glog.delete();
    for (int k = 0; k < 120 && glog.size() < 16; k++) begin
      if (!cpu_req[1]) begin cpu_req[1] = 1'b1; cpu_addr[1] = 14'($urandom); end
      if (!dma_req[1]) begin dma_req[1] = 1'b1; dma_addr[1] = 14'($urandom); end
      tick();
    end
    checks++; if (glog.size() < 16) begin errors++;
      $display("FAIL alt_grants: got %0d want 16", glog.size()); end
    n = 0;
    for (int k = 0; k < glog.size() && k < 16; k++) if (glog[k] != (k % 2)) n++;
    checks++; if (n != 0) begin errors++;
      $display("FAIL alt_order: got %0d out-of-turn grants want 0", n); end
    cpu_req[1] = 1'b0; dma_req[1] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_ws0();
    logic [13:0] a;
    a = 14'($urandom);
    dma_req[0] = 1'b1; dma_addr[0] = a;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rom_cs[0] !== (k == 1)) begin errors++;
        $display("FAIL ws0_cs k%0d: got %b want %b", k, rom_cs[0], k == 1); end
      checks++; if (dma_ack[0] !== (k == 2)) begin errors++;
        $display("FAIL ws0_ack k%0d: got %b want %b", k, dma_ack[0], k == 2); end
      tick();
    end
    checks++; if (dma_data[0] !== rom[a]) begin errors++;
      $display("FAIL ws0_data: got %h want %h", dma_data[0], rom[a]); end
  endtask

  task automatic test_addr_change();
    cpu_req[1] = 1'b1; cpu_addr[1] = 14'h0001;
    tick();
    cpu_addr[1] = 14'h0002;   // ignored: address was captured at grant
    for (int k = 1; k < 5; k++) begin
      if (k <= 2) begin
        checks++; if (rom_addr[1] !== 14'h0001) begin errors++;
          $display("FAIL addr_hold k%0d: got %h want 0001", k, rom_addr[1]); end
      end
      tick();
    end
    checks++; if (cpu_data[1] !== 8'h5A) begin errors++;
      $display("FAIL addr_change_data: got %h want 5a", cpu_data[1]); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!cpu_req[i] && $urandom_range(2) == 0) begin cpu_req[i] = 1'b1; cpu_addr[i] = 14'($urandom); end
        if (!dma_req[i] && $urandom_range(2) == 0) begin dma_req[i] = 1'b1; dma_addr[i] = 14'($urandom); end
      end
      tick();
    end
    repeat (16) tick();       // drain: pending requests are served, then idle
    checks++; if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin errors++;
      $display("FAIL random_drain: got busy %b%b want 00", busy[1], busy[0]); end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) rom[a] = 8'($urandom);
    rom[0] = 8'hF3; rom[1] = 8'h5A; rom[2] = 8'hA5;
    test_reset();
    test_cpu_only();
    test_reset_mid_access();
    test_both_same_edge();
    test_alternate();
    test_ws0();
    test_addr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
